// File: rtl/uart_wb_master.sv
// uart_wb_master: UART byte stream to 32-bit pipelined Wishbone master debug bridge
// Ports: clk_i/rst_i clock and synchronous active-high reset;
//   rx_data_i/rx_data_vld_i received bytes; tx_data_o/tx_data_vld_o/tx_active_i transmit handshake;
//   wb_* Wishbone master (cyc, stb, we, adr, dat, sel out; dat, ack, err, stall in);
//   busy_o high whenever a frame, bus cycle or response is in progress.
module uart_wb_master #(
    parameter int WB_TIMEOUT = 1024,
    parameter int RX_TIMEOUT = 500000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_data_vld_i,
    output logic [7:0]  tx_data_o,
    output logic        tx_data_vld_o,
    input  logic        tx_active_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i,
    output logic        busy_o
);
    localparam int RW = $clog2(RX_TIMEOUT);
    localparam int WW = $clog2(WB_TIMEOUT);
    localparam logic [RW-1:0] RX_LAST = RW'(RX_TIMEOUT - 1);
    localparam logic [WW-1:0] WB_LAST = WW'(WB_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, RX_ADDR, RX_DATA, WB_REQ, WB_WAIT, TX_SEND, TX_WAIT_HI, TX_WAIT_LO
    } state_t;

    state_t state, state_n;
    logic we;
    logic [31:0] adr, dat;
    logic [1:0] rx_cnt;
    logic [RW-1:0] rx_tmr;
    logic [WW-1:0] wb_tmr;
    logic [39:0] tx_sr;
    logic [2:0] tx_cnt;
    logic in_rx, in_wb, resp, wb_to, fail;

    assign in_rx = state == RX_ADDR || state == RX_DATA;
    assign in_wb = state == WB_REQ || state == WB_WAIT;
    // ack/err only count once the request has been accepted (stall low)
    assign resp  = ((state == WB_REQ && !wb_stall_i) || state == WB_WAIT) && (wb_ack_i || wb_err_i);
    assign wb_to = in_wb && wb_tmr == WB_LAST && !resp;
    assign fail  = !resp || wb_err_i;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:       state_n = rx_data_vld_i && (rx_data_i == 8'h57 || rx_data_i == 8'h52) ? RX_ADDR : IDLE;
            RX_ADDR:    state_n = rx_data_vld_i && rx_cnt == 2'd3 ? (we ? RX_DATA : WB_REQ) :
                                  !rx_data_vld_i && rx_tmr == RX_LAST ? IDLE : RX_ADDR;
            RX_DATA:    state_n = rx_data_vld_i && rx_cnt == 2'd3 ? WB_REQ :
                                  !rx_data_vld_i && rx_tmr == RX_LAST ? IDLE : RX_DATA;
            WB_REQ:     state_n = resp || wb_to ? TX_SEND : !wb_stall_i ? WB_WAIT : WB_REQ;
            WB_WAIT:    state_n = resp || wb_to ? TX_SEND : WB_WAIT;
            TX_SEND:    state_n = !tx_active_i ? TX_WAIT_HI : TX_SEND;
            TX_WAIT_HI: state_n = tx_active_i ? TX_WAIT_LO : TX_WAIT_HI;
            TX_WAIT_LO: state_n = tx_active_i ? TX_WAIT_LO : tx_cnt == 3'd1 ? IDLE : TX_SEND;
            default:    state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            we     <= 1'b0;
            adr    <= '0;
            dat    <= '0;
            rx_cnt <= '0;
            rx_tmr <= '0;
            wb_tmr <= '0;
            tx_sr  <= '0;
            tx_cnt <= '0;
        end else begin
            state  <= state_n;
            rx_tmr <= state == IDLE || rx_data_vld_i ? '0 : rx_tmr + 1'b1;
            wb_tmr <= in_wb ? wb_tmr + 1'b1 : '0;
            if (state == IDLE) begin
                rx_cnt <= '0;
                if (rx_data_vld_i) we <= rx_data_i == 8'h57;
            end
            if (in_rx && rx_data_vld_i) rx_cnt <= rx_cnt + 1'b1;
            if (state == RX_ADDR && rx_data_vld_i) adr <= {adr[23:0], rx_data_i};
            if (state == RX_DATA && rx_data_vld_i) dat <= {dat[23:0], rx_data_i};
            if (in_wb && (resp || wb_to)) begin
                tx_sr  <= fail ? {8'h45, 32'h0} : {8'h4B, we ? 32'h0 : wb_dat_i};
                tx_cnt <= fail || we ? 3'd1 : 3'd5;
            end
            if (state == TX_WAIT_LO && !tx_active_i) begin
                tx_sr  <= {tx_sr[31:0], 8'h00};
                tx_cnt <= tx_cnt - 1'b1;
            end
        end
    end

    assign wb_cyc_o      = in_wb;
    assign wb_stb_o      = state == WB_REQ;
    assign wb_we_o       = in_wb && we;
    assign wb_adr_o      = in_wb ? adr : '0;
    assign wb_dat_o      = in_wb && we ? dat : '0;
    assign wb_sel_o      = {4{in_wb}};
    assign tx_data_vld_o = state == TX_SEND && !tx_active_i;
    assign tx_data_o     = tx_data_vld_o ? tx_sr[39:32] : 8'h00;
    assign busy_o        = state != IDLE;
endmodule

// File: doc/uart_wb_master.md
Name: uart_wb_master

Overview:
- UART-to-Wishbone debug bridge that issues Wishbone master cycles and returns results through the UART.
- Consumes the byte stream from a UART receiver and decodes read/write command frames.
- Issues one 32-bit pipelined Wishbone master cycle per frame.
- Returns a status byte, plus read data for reads, through the UART transmitter byte interface.
- Sits between the uart core and the system bus, as the initiator end of the bus the UART peripherals respond on.

Parameters:
WB_TIMEOUT, 1024, max cycles from first stb to ack/err before abort (>=2)
RX_TIMEOUT, 500000, max idle cycles between bytes of one frame before frame is discarded (>=2)

Ports:
clk_i  input  1  system clock
rst_i  input  1  synchronous active-high reset
rx_data_i  input  8  received byte from uart
rx_data_vld_i  input  1  1-cycle strobe, rx_data_i valid
tx_data_o  output  8  byte to transmit
tx_data_vld_o  output  1  1-cycle strobe requesting transmission of tx_data_o
tx_active_i  input  1  uart transmitter busy
wb_cyc_o  output  1  bus cycle
wb_stb_o  output  1  strobe
wb_we_o  output  1  write enable
wb_adr_o  output  32  byte address
wb_dat_o  output  32  write data
wb_sel_o  output  4  byte select, always 4'hF during a cycle
wb_dat_i  input  32  read data
wb_ack_i  input  1  acknowledge
wb_err_i  input  1  error
wb_stall_i  input  1  slave stall
busy_o  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_i=1 at a clk_i edge, sampled synchronously):
  - State goes to IDLE.
  - All outputs go to 0; wb_sel_o=0.
  - Byte counters and timers are cleared.
  - Reset mid-cycle drops wb_cyc_o/wb_stb_o on the next edge; no response byte is sent.
- Frame format, multi-byte fields MSB first:
  - Write: 0x57, A3..A0, D3..D0.
  - Read: 0x52, A3..A0.
- Response format:
  - Write ok: 0x4B.
  - Read ok: 0x4B, R3..R0.
  - Any error or timeout: 0x45 only.
- States: IDLE, RX_ADDR, RX_DATA, WB_REQ, WB_WAIT, TX_SEND, TX_WAIT_HI, TX_WAIT_LO.
- IDLE:
  - rx 0x57 sets we=1 and goes to RX_ADDR; rx 0x52 sets we=0 and goes to RX_ADDR.
  - Any other byte is ignored; state stays IDLE.
- RX_ADDR:
  - Shifts 4 bytes into the address register.
  - After the 4th byte: write goes to RX_DATA, read goes to WB_REQ.
- RX_DATA: shifts 4 bytes into the data register, then goes to WB_REQ.
- RX timeout:
  - In RX_ADDR/RX_DATA, a cycle counter reloads on each rx_data_vld_i.
  - RX_TIMEOUT cycles without a byte returns the FSM to IDLE, discards the partial frame and sends no response.
- Bytes arriving in WB_REQ..TX_WAIT_LO are dropped and do not start a frame.
- WB_REQ:
  - Asserts cyc=stb=1, sel=F, we, adr, dat (dat=0 for reads).
  - Holds stb and all request fields while wb_stall_i=1.
  - At the first edge with wb_stall_i=0, stb drops and the FSM goes to WB_WAIT; cyc stays 1.
- ack/err in the same cycle as the accepted stb (stall=0) is honoured and completes immediately.
- WB_WAIT: cyc held until the first edge with ack or err.
  - ack: captures wb_dat_i (reads) and queues 0x4B (+4 bytes for reads).
  - err, or err together with ack: queues 0x45; err wins.
  - cyc drops the next cycle.
- WB timeout:
  - Counter starts at entry to WB_REQ.
  - After WB_TIMEOUT cycles with no ack/err, drops cyc/stb and queues 0x45.
- Response is queued as a byte count (1 or 5) plus a shift register.
- TX_SEND:
  - Waits for tx_active_i=0, then pulses tx_data_vld_o for 1 cycle with the current byte and goes to TX_WAIT_HI.
- TX_WAIT_HI:
  - Waits until tx_active_i=1.
  - Also proceeds if tx_active_i was already observed high in the pulse cycle.
  - No timeout.
- TX_WAIT_LO: waits until tx_active_i=0.
  - Then decrements the count; if bytes remain, goes to TX_SEND with the next byte, else goes to IDLE.
- Each cycle carries exactly one request; no pipelined back-to-back requests.

Test Plan:
- Write: rx 57 00 00 10 04 DE AD BE EF, slave acks 2 cycles after stb, no stall.
  - Expect one cycle with adr=0x00001004, dat=0xDEADBEEF, we=1, sel=F.
  - Expect stb high exactly 1 cycle, then tx byte 0x4B.
- Read with stall: rx 52 00 00 20 00, slave holds stall 3 cycles, then acks with dat_i=0x12345678.
  - Expect stb held 4 cycles with constant adr, then tx bytes 4B 12 34 56 78 in order.
  - Expect one vld pulse per tx_active_i low period.
- Error: read frame, slave returns err=1 with ack=1 in the same cycle.
  - Expect tx of 0x45 only; cyc low the next cycle.
- Bus timeout (WB_TIMEOUT=16): slave never responds.
  - Expect cyc dropped 16 cycles after stb rose and tx 0x45.
- RX timeout (RX_TIMEOUT=50): rx 57 00 00, then silence for 60 cycles, then a full valid read frame.
  - Expect no tx for the partial frame and a normal read for the second frame.
- Robustness: garbage bytes 00 FF 41 before a frame are ignored.
  - Bytes sent during tx are dropped.
  - rst_i asserted during WB_WAIT: cyc=0 next cycle, busy_o=0, no tx pulse.
